video_pattern_sequencer: RTL and testbench

VIDEO_PATTERN_SEQUENCER -- requirements
Module: video_pattern_sequencer

---
 rtl/video_pattern_sequencer.sv | 172 +++++++++++++++++
 tb/tb_video_pattern_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// video_pattern_sequencer
//
// Selects one of five test patterns and drives the RGB guns for a small video
// sync generator. Two push buttons (next pattern, toggle auto/manual) are
// synchronized and debounced. Their press events are held pending and applied
// only at a frame boundary (the rising edge of vsync), so a frame never mixes
// two patterns. In auto mode the pattern advances every AUTO_FRAMES frames. A
// heartbeat LED toggles every 30 frames.
//
// Ports
//   clk          pixel clock; the only clock in the block
//   reset        asynchronous, active-low reset
//   hpos, vpos   beam position from the sync generator (9 bits each)
//   display_on   high inside the visible region
//   vsync        active-high vertical sync, sampled as data
//   btn_next     asynchronous "next pattern" button, active-high
//   btn_mode     asynchronous "toggle auto/manual" button, active-high
//   rgb          registered {r,g,b}, one cycle after the beam inputs
//   pattern_sel  current pattern index, 0..4
//   auto_mode    high while patterns cycle automatically
//   frame_led    heartbeat LED
// ---------------------------------------------------------------------------
module video_pattern_sequencer #(
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       vsync,
    input  logic       btn_next,
    input  logic       btn_mode,
    output logic [2:0] rgb,
    output logic [2:0] pattern_sel,
    output logic       auto_mode,
    output logic       frame_led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       FRAME_LAST = 8'(AUTO_FRAMES - 1);
    localparam logic [4:0]       LED_LAST   = 5'd29;

    // Index 0 is btn_next, index 1 is btn_mode.
    logic [1:0]       btn_p0;
    logic [1:0]       btn_p1;
    logic [1:0]       btn_lvl;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [1:0]       press;

    logic       vsync_p0;
    logic       vsync_p1;
    logic       boundary;
    logic       advance;
    logic       pend_next;
    logic       pend_mode;
    logic [7:0] frame_cnt;
    logic [4:0] led_cnt;

    // Only the low bits of the beam position select bars, grid and checks.
    logic unused_pos;
    assign unused_pos = ^{hpos[8], vpos[8:6]};

    function automatic logic [2:0] pattern_rgb(input logic [2:0] sel,
                                               input logic [7:0] h,
                                               input logic [5:0] v);
        logic [2:0] c;
        c = 3'b000;
        case (sel)
            3'd0: c = {~h[6], ~h[7], ~h[5]};
            3'd1: c = 3'b111;
            3'd2: c = ((h[4:0] == 5'd0) || (v[4:0] == 5'd0)) ? 3'b111 : 3'b000;
            3'd3: c = {3{h[5] ^ v[5]}};
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    always_comb begin
        press = 2'b00;
        for (int i = 0; i < 2; i++) begin
            // The accepting cycle of a 0->1 level change is the press event.
            press[i] = btn_p1[i] && !btn_lvl[i] && (deb_cnt[i] == CNT_LAST);
        end
        boundary = vsync_p0 && !vsync_p1;
        advance  = pend_next || (auto_mode && (frame_cnt == FRAME_LAST));
    end

    // Stage p0/p1: two-flop synchronizer, then debounce on the p1 level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_p0  <= 2'b00;
            btn_p1  <= 2'b00;
            btn_lvl <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_p0 <= {btn_mode, btn_next};
            btn_p1 <= btn_p0;
            for (int i = 0; i < 2; i++) begin
                if (btn_p1[i] == btn_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    btn_lvl[i] <= btn_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stage p0/p1: vsync history for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_p0 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            vsync_p0 <= vsync;
            vsync_p1 <= vsync_p0;
        end
    end

    // Frame-boundary control. A press arriving on the boundary cycle itself
    // becomes the new pending flag rather than being cleared with the old one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_sel <= 3'd0;
            auto_mode   <= 1'b0;
            frame_led   <= 1'b0;
            pend_next   <= 1'b0;
            pend_mode   <= 1'b0;
            frame_cnt   <= 8'd0;
            led_cnt     <= 5'd0;
        end else if (boundary) begin
            if (advance) begin
                pattern_sel <= (pattern_sel == 3'd4) ? 3'd0 : pattern_sel + 3'd1;
            end
            auto_mode <= auto_mode ^ pend_mode;
            if (pend_mode || advance || !auto_mode) begin
                frame_cnt <= 8'd0;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            pend_next <= press[0];
            pend_mode <= press[1];
            if (led_cnt == LED_LAST) begin
                led_cnt   <= 5'd0;
                frame_led <= ~frame_led;
            end else begin
                led_cnt <= led_cnt + 5'd1;
            end
        end else begin
            pend_next <= pend_next | press[0];
            pend_mode <= pend_mode | press[1];
        end
    end

    // Stage p0: registered gun drive, blanked outside the visible region.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb <= 3'b000;
        end else begin
            rgb <= display_on ? pattern_rgb(pattern_sel, hpos[7:0], vpos[5:0]) : 3'b000;
        end
    end

endmodule

// File: tb/tb_video_pattern_sequencer.sv
module tb_video_pattern_sequencer;

    localparam int DEB = 4;
    localparam int AF  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] hpos = 9'd0;
    logic [8:0] vpos = 9'd0;
    logic       display_on = 1'b0;
    logic       vsync = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_mode = 1'b0;
    logic [2:0] rgb;
    logic [2:0] pattern_sel;
    logic       auto_mode;
    logic       frame_led;

    int checks = 0;
    int failures = 0;

    video_pattern_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_FRAMES    (AF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .vsync      (vsync),
        .btn_next   (btn_next),
        .btn_mode   (btn_mode),
        .rgb        (rgb),
        .pattern_sel(pattern_sel),
        .auto_mode  (auto_mode),
        .frame_led  (frame_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit         nh[$];
    bit         mh[$];
    bit         vh[$];
    bit         m_acc_n, m_acc_m, m_pend_n, m_pend_m, m_auto, m_led;
    int         m_sel, m_fc, m_lc;
    logic [2:0] m_rgb;
    bit         ev_n, ev_m, bnd, adv;

    function automatic logic [2:0] pat(input int sel, input logic [8:0] h, input logic [8:0] v);
        case (sel)
            0: return {~h[6], ~h[7], ~h[5]};
            1: return 3'b111;
            2: return ((h % 32) == 0 || (v % 32) == 0) ? 3'b111 : 3'b000;
            3: return (h[5] != v[5]) ? 3'b111 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    // True when the synchronized samples (two cycles old and older) have all
    // been at lvl for DEB consecutive cycles.
    function automatic bit held(input bit q[$], input bit lvl);
        for (int i = 2; i < 2 + DEB; i++) begin
            if (q[i] != lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        nh.delete(); mh.delete(); vh.delete();
        for (int i = 0; i < DEB + 4; i++) begin
            nh.push_back(1'b0); mh.push_back(1'b0); vh.push_back(1'b0);
        end
        m_acc_n = 0; m_acc_m = 0; m_pend_n = 0; m_pend_m = 0;
        m_auto = 0; m_led = 0; m_sel = 0; m_fc = 0; m_lc = 0; m_rgb = 3'b000;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            nh.push_front(btn_next); void'(nh.pop_back());
            mh.push_front(btn_mode); void'(mh.pop_back());
            vh.push_front(vsync);    void'(vh.pop_back());
            ev_n = 0;
            ev_m = 0;
            if (!m_acc_n && held(nh, 1'b1)) begin m_acc_n = 1; ev_n = 1; end
            else if (m_acc_n && held(nh, 1'b0)) m_acc_n = 0;
            if (!m_acc_m && held(mh, 1'b1)) begin m_acc_m = 1; ev_m = 1; end
            else if (m_acc_m && held(mh, 1'b0)) m_acc_m = 0;
            bnd = vh[1] && !vh[2];
            m_rgb = display_on ? pat(m_sel, hpos, vpos) : 3'b000;
            if (bnd) begin
                adv = m_pend_n || (m_auto && m_fc == AF - 1);
                if (m_pend_m || adv || !m_auto) m_fc = 0;
                else m_fc = m_fc + 1;
                if (adv) m_sel = (m_sel + 1) % 5;
                if (m_pend_m) m_auto = !m_auto;
                m_pend_n = ev_n;
                m_pend_m = ev_m;
                m_lc = m_lc + 1;
                if (m_lc == 30) begin
                    m_lc = 0;
                    m_led = !m_led;
                end
            end else begin
                m_pend_n = m_pend_n | ev_n;
                m_pend_m = m_pend_m | ev_m;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("rgb", int'(rgb), int'(m_rgb));
        chk("pattern_sel", int'(pattern_sel), m_sel);
        chk("auto_mode", int'(auto_mode), int'(m_auto));
        chk("frame_led", int'(frame_led), int'(m_led));
    end

    // Heartbeat toggle counter for the LED test.
    bit led_cnt_en = 0;
    bit led_prev = 0;
    int led_toggles = 0;
    always @(negedge clk) begin
        if (led_cnt_en && (frame_led != led_prev)) led_toggles++;
        led_prev = frame_led;
    end

    // ---------------- stimulus ----------------
    task automatic rand_beam();
        hpos = 9'($urandom);
        vpos = 9'($urandom);
        if ($urandom_range(3) == 0) hpos[4:0] = 5'd0;
        if ($urandom_range(7) == 0) vpos[4:0] = 5'd0;
        display_on = ($urandom_range(3) != 0);
    endtask

    // One frame of len cycles; vsync is high for the last four cycles. Each
    // button is held high from cycle *_on for *_len cycles (0 = no press).
    task automatic frame(input int len, input int n_on, input int n_len,
                         input int m_on, input int m_len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rand_beam();
            vsync    = (i >= len - 4);
            btn_next = (n_len > 0) && (i >= n_on) && (i < n_on + n_len);
            btn_mode = (m_len > 0) && (i >= m_on) && (i < m_on + m_len);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        btn_next = 0; btn_mode = 0; vsync = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_sel", int'(pattern_sel), 0);
        chk("reset_auto", int'(auto_mode), 0);
        chk("reset_led", int'(frame_led), 0);
        reset = 1'b1;

        // Colour bars pinned by hand.
        @(negedge clk);
        hpos = 9'h020; vpos = 9'h000; display_on = 1'b1;
        @(negedge clk);
        chk("bars_h20", int'(rgb), 3'b110);
        hpos = 9'h0C0;
        @(negedge clk);
        chk("bars_hC0", int'(rgb), 3'b001);
        display_on = 1'b0; hpos = 9'h020;
        @(negedge clk);
        chk("bars_blank", int'(rgb), 0);

        // Short press is filtered, long press advances at the boundary.
        frame(24, 4, 3, 0, 0);
        chk("short_press", int'(pattern_sel), 0);
        frame(24, 4, 8, 0, 0);
        chk("press_1", int'(pattern_sel), 1);
        for (int k = 2; k <= 5; k++) begin
            frame(24, 4, 8, 0, 0);
            chk("press_seq", int'(pattern_sel), k % 5);
        end

        // Auto mode.
        frame(24, 0, 0, 4, 8);
        chk("auto_on", int'(auto_mode), 1);
        chk("auto_sel0", int'(pattern_sel), 0);
        frame(24, 0, 0, 0, 0);
        frame(24, 0, 0, 0, 0);
        chk("auto_hold", int'(pattern_sel), 0);
        frame(24, 0, 0, 0, 0);
        chk("auto_adv", int'(pattern_sel), 1);
        frame(24, 4, 8, 0, 0);
        chk("auto_next", int'(pattern_sel), 2);
        frame(24, 0, 0, 0, 0);
        frame(24, 0, 0, 0, 0);
        chk("auto_restart", int'(pattern_sel), 2);
        frame(24, 0, 0, 0, 0);
        chk("auto_adv2", int'(pattern_sel), 3);
        frame(24, 0, 0, 4, 8);
        chk("auto_off", int'(auto_mode), 0);

        // Press whose event lands on the boundary cycle itself.
        frame(24, 16, 8, 0, 0);
        chk("coincide_hold", int'(pattern_sel), 3);
        frame(24, 0, 0, 0, 0);
        chk("coincide_next", int'(pattern_sel), 4);
        frame(24, 0, 0, 0, 0);
        chk("coincide_once", int'(pattern_sel), 4);

        // Randomized frames and presses.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(40, 12);
            frame(len,
                  $urandom_range(len - 1), ($urandom_range(2) == 0) ? $urandom_range(10, 1) : 0,
                  $urandom_range(len - 1), ($urandom_range(4) == 0) ? $urandom_range(10, 1) : 0);
        end

        // Heartbeat: 60 boundaries after reset.
        do_reset();
        led_toggles = 0;
        led_cnt_en = 1;
        for (int f = 0; f < 60; f++) frame(12, 0, 0, 0, 0);
        led_cnt_en = 0;
        chk("led_toggles", led_toggles, 2);
        chk("led_final", int'(frame_led), 0);

        // Asynchronous reset mid-frame.
        frame(24, 4, 8, 0, 0);
        @(negedge clk);
        vsync = 0; hpos = 9'h011; display_on = 1'b1;
        @(negedge clk);
        chk("white", int'(rgb), 3'b111);
        #2 reset = 1'b0;
        #1;
        chk("async_rgb", int'(rgb), 0);
        chk("async_sel", int'(pattern_sel), 0);
        chk("async_auto", int'(auto_mode), 0);
        chk("async_led", int'(frame_led), 0);
        @(negedge clk);
        reset = 1'b1;
        frame(24, 0, 0, 0, 0);
        chk("after_reset_sel", int'(pattern_sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
